demultiplexor_reg: RTL

DEMULTIPLEXOR_REG -- requirements
Module: demultiplexor_reg

---
 rtl/demultiplexor_reg.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/demultiplexor_reg.sv
// -----------------------------------------------------------------------------
// demultiplexor_reg
//
// Routes a data word to one of eleven registered destinations. The destination
// comes from the manual select (ss) or from an internal wrapping sequencer
// (cur_ss). A two-state FSM (RDY/ERR) guards writes. A manual write to a
// nonexistent destination (ss 11..15) moves the FSM to ERR. In ERR, writes are
// refused until err_clr is asserted.
//
// Handshake: a write is accepted on a rising clk edge where valid=1 and
// ready=1. ready is decoded from the FSM state alone, so it never depends
// combinationally on valid. An accepted write shows up on its destination
// register, and on the matching upd bit, in the following cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din[n]       data word to route
//   ss[4]        manual destination select (0..10 valid)
//   auto         1: use sequencer pointer cur_ss, 0: use ss
//   valid        write request for the current cycle
//   err_clr      leaves ERR at the next edge (ignored in RDY)
//   ready        1 while in RDY
//   out_a..out_k registered destinations 0..10
//   upd[11]      one-hot pulse, bit i = destination i written last edge
//   cur_ss[4]    sequencer pointer, 0..10
//   err          1 while in ERR (doubles as the FSM state debug view)
// -----------------------------------------------------------------------------
module demultiplexor_reg #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] din,
  input  logic [3:0]   ss,
  input  logic         auto,
  input  logic         valid,
  input  logic         err_clr,
  output logic         ready,
  output logic [n-1:0] out_a,
  output logic [n-1:0] out_b,
  output logic [n-1:0] out_c,
  output logic [n-1:0] out_d,
  output logic [n-1:0] out_e,
  output logic [n-1:0] out_f,
  output logic [n-1:0] out_g,
  output logic [n-1:0] out_h,
  output logic [n-1:0] out_i,
  output logic [n-1:0] out_j,
  output logic [n-1:0] out_k,
  output logic [10:0]  upd,
  output logic [3:0]   cur_ss,
  output logic         err
);

  localparam int          NUM_DEST = 11;
  localparam logic [3:0]  LAST_IDX = 4'd10;

  typedef enum logic {
    RDY = 1'b0,
    ERR = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [n-1:0]  regs [NUM_DEST];
  logic          accept;
  logic [3:0]    target;
  logic          in_range;
  logic          wr;
  logic [10:0]   upd_nxt;

  assign accept   = valid & ready;
  // In auto mode the sequencer pointer is the target and ss is ignored.
  assign target   = auto ? cur_ss : ss;
  assign in_range = (target <= LAST_IDX);
  assign wr       = accept & in_range;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RDY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      RDY: begin
        // err_clr has no effect here; a bad manual select still trips ERR.
        if (accept && !auto && (ss > LAST_IDX)) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        if (err_clr) begin
          state_nxt = RDY;
        end
      end
      default: state_nxt = RDY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    case (state)
      RDY:     ready = 1'b1;
      ERR:     err   = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // One-hot decode of the write target. It is zero whenever no write happens.
  always_comb begin
    upd_nxt = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      upd_nxt[i] = wr && (target == 4'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Destination registers, update pulse and sequencer pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        regs[i] <= '0;
      end
      upd    <= '0;
      cur_ss <= '0;
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (upd_nxt[i]) begin
          regs[i] <= din;
        end
      end
      upd <= upd_nxt;
      // The pointer moves only on auto-mode accepts and wraps 10 -> 0.
      if (accept && auto) begin
        cur_ss <= (cur_ss >= LAST_IDX) ? 4'd0 : cur_ss + 4'd1;
      end
    end
  end

  assign out_a = regs[0];
  assign out_b = regs[1];
  assign out_c = regs[2];
  assign out_d = regs[3];
  assign out_e = regs[4];
  assign out_f = regs[5];
  assign out_g = regs[6];
  assign out_h = regs[7];
  assign out_i = regs[8];
  assign out_j = regs[9];
  assign out_k = regs[10];

endmodule
